// File: rtl/slurm16_flash_dma_pkg.sv
// slurm16_flash_dma shared definitions.
// Register map, SPI opcode, FSM and shift-length enums.
package slurm16_flash_dma_pkg;

  localparam logic [3:0] REG_FLASH_LO  = 4'd0;
  localparam logic [3:0] REG_FLASH_HI  = 4'd1;
  localparam logic [3:0] REG_DMA_ADDR  = 4'd2;
  localparam logic [3:0] REG_DMA_COUNT = 4'd3;
  localparam logic [3:0] REG_CMD       = 4'd4;
  localparam logic [3:0] REG_STATUS    = 4'd5;

  localparam logic [7:0] SPI_CMD_READ = 8'h03;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CMD,
    ST_DATA,
    ST_WRITE,
    ST_ACK,
    ST_DONE
  } state_e;

  typedef enum logic [1:0] {
    LEN_8,
    LEN_16,
    LEN_32
  } spi_len_e;

endpackage

// File: rtl/slurm16_spi_shifter.sv
// CLK_DIV-paced mode-0 SPI shift engine.
// MSB-first out, MISO sampled on the CLK where SCK rises.
module slurm16_spi_shifter
  import slurm16_flash_dma_pkg::*;
#(
  parameter int CLK_DIV = 1
) (
  input  logic        CLK,
  input  logic        RSTb,
  input  logic        start,
  input  spi_len_e    len,
  input  logic [31:0] tx_data,
  output logic [15:0] rx_data,
  output logic        done,
  output logic        SCK,
  output logic        MOSI,
  input  logic        MISO
);

  logic [31:0] sreg;
  logic [15:0] div_cnt;
  logic [5:0]  bit_cnt;
  logic [5:0]  len_bits;
  logic        active;
  logic        last_div;

  assign last_div = (div_cnt == 16'(CLK_DIV - 1));
  assign MOSI     = sreg[31];

  always_comb begin
    len_bits = 6'd32;
    unique case (len)
      LEN_8:   len_bits = 6'd8;
      LEN_16:  len_bits = 6'd16;
      default: len_bits = 6'd32;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RSTb) begin
      sreg    <= '0;
      rx_data <= '0;
      div_cnt <= '0;
      bit_cnt <= '0;
      active  <= 1'b0;
      done    <= 1'b0;
      SCK     <= 1'b0;
    end else begin
      done <= 1'b0;
      if (start) begin
        active  <= 1'b1;
        SCK     <= 1'b0;
        div_cnt <= '0;
        sreg    <= tx_data;
        bit_cnt <= len_bits;
      end else if (active) begin
        if (last_div) begin
          div_cnt <= '0;
          SCK     <= ~SCK;
          if (!SCK) begin
            rx_data <= {rx_data[14:0], MISO};
          end else begin
            // falling edge: advance MOSI to the next bit
            sreg    <= {sreg[30:0], 1'b0};
            bit_cnt <= bit_cnt - 6'd1;
            if (bit_cnt == 6'd1) begin
              active <= 1'b0;
              done   <= 1'b1;
            end
          end
        end else begin
          div_cnt <= div_cnt + 16'd1;
        end
      end
    end
  end

endmodule

// File: rtl/slurm16_flash_dma.sv
// SPI flash to memory DMA engine for the SLURM16 arbiter.
// Issues READ 0x03, streams little-endian words to memory.
module slurm16_flash_dma
  import slurm16_flash_dma_pkg::*;
#(
  parameter int CLK_DIV = 1
) (
  input  logic        CLK,
  input  logic        RSTb,
  input  logic [3:0]  ADDRESS,
  input  logic [15:0] DATA_IN,
  output logic [15:0] DATA_OUT,
  input  logic        WR,
  output logic        SCK,
  output logic        MOSI,
  input  logic        MISO,
  output logic        CS_b,
  output logic [15:0] fl_memory_address,
  output logic [15:0] fl_memory_data,
  output logic        fl_wvalid,
  input  logic        fl_wready,
  output logic        irq
);

  state_e state, state_d;

  logic [15:0] flash_lo;
  logic [7:0]  flash_hi;
  logic [15:0] dma_addr;
  logic [15:0] dma_count;
  logic [15:0] remain;
  logic        done_flag;
  logic        busy;
  logic        start_req;
  logic        done_clr;
  logic        wr_en;
  logic [15:0] rd_data;

  logic        sh_start;
  spi_len_e    sh_len;
  logic [31:0] sh_tx;
  logic [15:0] sh_rx;
  logic        sh_done;

  slurm16_spi_shifter #(
    .CLK_DIV (CLK_DIV)
  ) u_shifter (
    .CLK     (CLK),
    .RSTb    (RSTb),
    .start   (sh_start),
    .len     (sh_len),
    .tx_data (sh_tx),
    .rx_data (sh_rx),
    .done    (sh_done),
    .SCK     (SCK),
    .MOSI    (MOSI),
    .MISO    (MISO)
  );

  assign busy  = (state != ST_IDLE);
  assign wr_en = WR && !busy;

  assign start_req = WR && (ADDRESS == REG_CMD)
                   && DATA_IN[0] && (state == ST_IDLE);
  assign done_clr  = WR && (ADDRESS == REG_STATUS)
                   && DATA_IN[1];

  always_ff @(posedge CLK) begin
    if (!RSTb) state <= ST_IDLE;
    else       state <= state_d;
  end

  always_comb begin
    state_d  = state;
    sh_start = 1'b0;
    sh_len   = LEN_16;
    sh_tx    = '0;
    unique case (state)
      ST_IDLE: begin
        if (start_req) begin
          if (dma_count == 16'd0) begin
            state_d = ST_DONE;
          end else begin
            state_d  = ST_CMD;
            sh_start = 1'b1;
            sh_len   = LEN_32;
            sh_tx    = {SPI_CMD_READ, flash_hi, flash_lo};
          end
        end
      end
      ST_CMD: begin
        if (sh_done) begin
          state_d  = ST_DATA;
          sh_start = 1'b1;
        end
      end
      ST_DATA: begin
        if (sh_done) state_d = ST_WRITE;
      end
      ST_WRITE: begin
        if (fl_wready) state_d = ST_ACK;
      end
      // ACK is one cycle and ignores a lingering wready
      ST_ACK: begin
        if (remain != 16'd0) begin
          state_d  = ST_DATA;
          sh_start = 1'b1;
        end else begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    rd_data = '0;
    unique case (1'b1)
      ADDRESS == REG_FLASH_LO:  rd_data = flash_lo;
      ADDRESS == REG_FLASH_HI:  rd_data = {8'h00, flash_hi};
      ADDRESS == REG_DMA_ADDR:  rd_data = dma_addr;
      ADDRESS == REG_DMA_COUNT: rd_data = dma_count;
      ADDRESS == REG_STATUS:    rd_data = {14'd0, done_flag, busy};
      default: ;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RSTb) begin
      flash_lo          <= '0;
      flash_hi          <= '0;
      dma_addr          <= '0;
      dma_count         <= '0;
      remain            <= '0;
      done_flag         <= 1'b0;
      DATA_OUT          <= '0;
      CS_b              <= 1'b1;
      fl_wvalid         <= 1'b0;
      fl_memory_address <= '0;
      fl_memory_data    <= '0;
      irq               <= 1'b0;
    end else begin
      DATA_OUT <= rd_data;
      if (wr_en) begin
        unique case (1'b1)
          ADDRESS == REG_FLASH_LO:  flash_lo  <= DATA_IN;
          ADDRESS == REG_FLASH_HI:  flash_hi  <= DATA_IN[7:0];
          ADDRESS == REG_DMA_ADDR:  dma_addr  <= DATA_IN;
          ADDRESS == REG_DMA_COUNT: dma_count <= DATA_IN;
          default: ;
        endcase
      end
      CS_b      <= (state_d == ST_IDLE) || (state_d == ST_DONE);
      fl_wvalid <= (state_d == ST_WRITE);
      irq       <= (state_d == ST_DONE);
      if (state_d == ST_DONE)  done_flag <= 1'b1;
      else if (done_clr)       done_flag <= 1'b0;
      if (start_req) begin
        fl_memory_address <= dma_addr;
        remain            <= dma_count;
      end
      // first received byte is the low half of the word
      if (state == ST_DATA && sh_done)
        fl_memory_data <= {sh_rx[7:0], sh_rx[15:8]};
      if (state == ST_WRITE && fl_wready) begin
        fl_memory_address <= fl_memory_address + 16'd1;
        remain            <= remain - 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_slurm16_flash_dma.sv
// Directed bench for slurm16_flash_dma with flash,
// arbiter and write-monitor models.
module tb_slurm16_flash_dma;

  logic        CLK = 1'b0;
  logic        RSTb;
  logic [3:0]  ADDRESS;
  logic [15:0] DATA_IN;
  logic [15:0] DATA_OUT;
  logic        WR;
  logic        SCK;
  logic        MOSI;
  logic        MISO;
  logic        CS_b;
  logic [15:0] fl_memory_address;
  logic [15:0] fl_memory_data;
  logic        fl_wvalid;
  logic        fl_wready;
  logic        irq;

  slurm16_flash_dma #(
    .CLK_DIV (1)
  ) dut (
    .CLK               (CLK),
    .RSTb              (RSTb),
    .ADDRESS           (ADDRESS),
    .DATA_IN           (DATA_IN),
    .DATA_OUT          (DATA_OUT),
    .WR                (WR),
    .SCK               (SCK),
    .MOSI              (MOSI),
    .MISO              (MISO),
    .CS_b              (CS_b),
    .fl_memory_address (fl_memory_address),
    .fl_memory_data    (fl_memory_data),
    .fl_wvalid         (fl_wvalid),
    .fl_wready         (fl_wready),
    .irq               (irq)
  );

  always #5 CLK = ~CLK;

  int nchk  = 0;
  int nfail = 0;

  // flash model: shifts in command, returns fl_bytes
  logic [7:0]  fl_bytes [0:7];
  logic [31:0] fl_cmd;
  int          fl_cnt;
  logic        sck_q;

  initial begin
    MISO   = 1'b0;
    fl_cmd = '0;
    fl_cnt = 0;
    sck_q  = 1'b0;
    forever begin
      @(negedge CLK);
      if (CS_b !== 1'b0) begin
        fl_cnt = 0;
      end else if (SCK && !sck_q) begin
        if (fl_cnt < 32) fl_cmd = {fl_cmd[30:0], MOSI};
        fl_cnt++;
      end else if (!SCK && sck_q && fl_cnt >= 32) begin
        if (fl_cnt < 96)
          MISO = fl_bytes[(fl_cnt - 32) / 8][7 - ((fl_cnt - 32) % 8)];
      end
      sck_q = SCK;
    end
  end

  // arbiter model
  int stall  = 0;
  int linger = 0;

  initial begin
    fl_wready = 1'b0;
    forever begin
      @(posedge CLK); #1;
      if (fl_wvalid && !fl_wready) begin
        repeat (stall) begin @(posedge CLK); #1; end
        fl_wready = 1'b1;
        @(posedge CLK); #1;
        repeat (linger) begin @(posedge CLK); #1; end
        fl_wready = 1'b0;
      end
    end
  end

  // write / irq / chip-select monitor
  logic [15:0] w_addr [0:31];
  logic [15:0] w_data [0:31];
  int nw      = 0;
  int irq_cnt = 0;
  int cs_low  = 0;

  always @(posedge CLK) begin
    if (RSTb === 1'b1) begin
      if (fl_wvalid && fl_wready && nw < 32) begin
        w_addr[nw] = fl_memory_address;
        w_data[nw] = fl_memory_data;
        nw++;
      end
      if (irq) irq_cnt++;
      if (!CS_b) cs_low++;
    end
  end

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    nchk++;
    assert (got === exp) else begin
      nfail++;
      $error("FAIL %s: observed %h expected %h",
             tag, got, exp);
    end
  endtask

  task automatic wr_reg(input logic [3:0] a,
                        input logic [15:0] d);
    @(negedge CLK);
    ADDRESS = a;
    DATA_IN = d;
    WR      = 1'b1;
    @(negedge CLK);
    WR = 1'b0;
  endtask

  task automatic rd_reg(input logic [3:0] a,
                        output logic [15:0] d);
    @(negedge CLK);
    ADDRESS = a;
    WR      = 1'b0;
    @(negedge CLK);
    d = DATA_OUT;
  endtask

  task automatic wait_irq(input string tag, input int maxc);
    int s0;
    bit ok;
    s0 = irq_cnt;
    ok = 1'b0;
    for (int i = 0; i < maxc && !ok; i++) begin
      @(negedge CLK);
      if (irq_cnt != s0) ok = 1'b1;
    end
    check(tag, {31'd0, ok}, 32'd1);
  endtask

  logic [15:0] rd;
  logic [15:0] a0, d0;
  int  n0, i0, c0;
  bit  ok, stable;

  initial begin
    RSTb    = 1'b0;
    ADDRESS = '0;
    DATA_IN = '0;
    WR      = 1'b0;
    for (int i = 0; i < 8; i++) fl_bytes[i] = 8'h00;
    repeat (3) @(negedge CLK);
    RSTb = 1'b1;

    // reset state
    check("rst_cs_b", CS_b, 1);
    check("rst_sck_mosi", {SCK, MOSI}, 0);
    check("rst_wvalid_irq", {fl_wvalid, irq}, 0);
    check("rst_addr", fl_memory_address, 0);
    check("rst_data", fl_memory_data, 0);
    check("rst_data_out", DATA_OUT, 0);
    rd_reg(4'd5, rd);
    check("rst_status", rd, 0);

    // basic transfer
    fl_bytes[0] = 8'hAA; fl_bytes[1] = 8'hBB;
    fl_bytes[2] = 8'hCC; fl_bytes[3] = 8'hDD;
    wr_reg(4'd0, 16'h2345);
    wr_reg(4'd1, 16'h0001);
    wr_reg(4'd2, 16'h4000);
    wr_reg(4'd3, 16'h0002);
    rd_reg(4'd1, rd);
    check("rd_flash_hi", rd, 16'h0001);
    n0 = nw; i0 = irq_cnt;
    wr_reg(4'd4, 16'h0001);
    check("basic_cs_fall", CS_b, 0);
    rd_reg(4'd5, rd);
    check("basic_busy", rd, 16'h0001);
    wait_irq("basic_timeout", 500);
    check("basic_cmd", fl_cmd, 32'h03012345);
    check("basic_nw", nw - n0, 2);
    check("basic_a0", w_addr[n0], 16'h4000);
    check("basic_d0", w_data[n0], 16'hBBAA);
    check("basic_a1", w_addr[n0+1], 16'h4001);
    check("basic_d1", w_data[n0+1], 16'hDDCC);
    rd_reg(4'd5, rd);
    check("basic_status", rd, 16'h0002);
    repeat (3) @(negedge CLK);
    check("basic_irq_once", irq_cnt - i0, 1);
    check("basic_cs_high", CS_b, 1);

    // lingering wready
    linger = 2;
    fl_bytes[0] = 8'h11; fl_bytes[1] = 8'h22;
    fl_bytes[2] = 8'h33; fl_bytes[3] = 8'h44;
    wr_reg(4'd2, 16'h2000);
    n0 = nw;
    wr_reg(4'd4, 16'h0001);
    wait_irq("linger_timeout", 500);
    check("linger_nw", nw - n0, 2);
    check("linger_a0", w_addr[n0], 16'h2000);
    check("linger_d0", w_data[n0], 16'h2211);
    check("linger_a1", w_addr[n0+1], 16'h2001);
    check("linger_d1", w_data[n0+1], 16'h4433);
    linger = 0;

    // arbiter stall
    stall = 50;
    fl_bytes[0] = 8'h5A; fl_bytes[1] = 8'hC3;
    wr_reg(4'd2, 16'h1000);
    wr_reg(4'd3, 16'h0001);
    n0 = nw;
    wr_reg(4'd4, 16'h0001);
    ok = 1'b0;
    for (int i = 0; i < 300 && !ok; i++) begin
      @(negedge CLK);
      if (fl_wvalid) ok = 1'b1;
    end
    check("stall_wvalid_seen", {31'd0, ok}, 1);
    a0 = fl_memory_address;
    d0 = fl_memory_data;
    stable = 1'b1;
    repeat (45) begin
      @(negedge CLK);
      if (fl_wvalid !== 1'b1 || fl_memory_address !== a0 ||
          fl_memory_data !== d0 || nw != n0)
        stable = 1'b0;
    end
    check("stall_stable", {31'd0, stable}, 1);
    check("stall_addr", a0, 16'h1000);
    check("stall_data", d0, 16'hC35A);
    wait_irq("stall_timeout", 200);
    check("stall_nw", nw - n0, 1);
    stall = 0;

    // zero count
    wr_reg(4'd5, 16'h0002);
    rd_reg(4'd5, rd);
    check("done_clear", rd, 0);
    wr_reg(4'd3, 16'h0000);
    c0 = cs_low; i0 = irq_cnt;
    wr_reg(4'd4, 16'h0001);
    @(negedge CLK);
    check("zero_irq", irq_cnt - i0, 1);
    rd_reg(4'd5, rd);
    check("zero_status", rd, 16'h0002);
    check("zero_no_cs", cs_low - c0, 0);

    // address wrap and ignored write
    fl_bytes[0] = 8'h01; fl_bytes[1] = 8'h02;
    fl_bytes[2] = 8'h03; fl_bytes[3] = 8'h04;
    wr_reg(4'd2, 16'hFFFF);
    wr_reg(4'd3, 16'h0002);
    n0 = nw;
    wr_reg(4'd4, 16'h0001);
    wr_reg(4'd0, 16'hBEEF);
    wait_irq("wrap_timeout", 500);
    check("wrap_nw", nw - n0, 2);
    check("wrap_a0", w_addr[n0], 16'hFFFF);
    check("wrap_d0", w_data[n0], 16'h0201);
    check("wrap_a1", w_addr[n0+1], 16'h0000);
    check("wrap_d1", w_data[n0+1], 16'h0403);
    rd_reg(4'd0, rd);
    check("wrap_flash_lo_kept", rd, 16'h2345);

    // reset mid-transfer
    wr_reg(4'd2, 16'h3000);
    wr_reg(4'd3, 16'h0004);
    wr_reg(4'd4, 16'h0001);
    repeat (80) @(negedge CLK);
    check("midrst_active", CS_b, 0);
    RSTb = 1'b0;
    @(negedge CLK);
    check("midrst_cs_b", CS_b, 1);
    check("midrst_wvalid", fl_wvalid, 0);
    RSTb = 1'b1;
    rd_reg(4'd0, rd);
    check("midrst_flash_lo", rd, 0);
    rd_reg(4'd1, rd);
    check("midrst_flash_hi", rd, 0);
    rd_reg(4'd2, rd);
    check("midrst_dma_addr", rd, 0);
    rd_reg(4'd3, rd);
    check("midrst_dma_count", rd, 0);
    rd_reg(4'd5, rd);
    check("midrst_status", rd, 0);

    $display("%0d/%0d checks passed", nchk - nfail, nchk);
    $finish;
  end

endmodule

// File: doc/slurm16_flash_dma.md
# slurm16_flash_dma

SPI-flash-to-memory DMA engine that feeds the flash port of the SLURM16 memory arbiter. The CPU programs a flash byte address, a destination word address and a word count through a small register port, then starts a transfer. The block issues a standard SPI READ (0x03) and streams 16-bit words into memory over the fl_wvalid/fl_wready handshake. It raises a done flag and interrupt on completion.

## Interface
Parameters:
- CLK_DIV, 1, SCK half-period in CLK cycles (≥1).

Ports. Clock is `CLK`; reset is `RSTb`, synchronous and active-low.
- CLK  in  1  system clock
- RSTb  in  1  synchronous active-low reset
- ADDRESS  in  4  register select
- DATA_IN  in  16  register write data
- DATA_OUT  out  16  register read data
- WR  in  1  register write strobe
- SCK  out  1  SPI clock, mode 0
- MOSI  out  1  SPI data out
- MISO  in  1  SPI data in
- CS_b  out  1  flash chip select, active-low
- fl_memory_address  out  16  destination word address
- fl_memory_data  out  16  write data
- fl_wvalid  out  1  write request
- fl_wready  in  1  write accepted (from arbiter)
- irq  out  1  one-cycle pulse on transfer completion

## Operation
Registers:
- 0 FLASH_LO: flash byte address [15:0].
- 1 FLASH_HI: flash byte address [23:16] in bits [7:0].
- 2 DMA_ADDR: memory word address.
- 3 DMA_COUNT: number of words.
- 4 CMD: write with bit0=1 → start.
- 5 STATUS: bit0 busy, bit1 done (sticky). Writing 1 to bit1 clears done.

Register rules:
- Writes to registers 0–4 while busy are ignored.
- A start with DMA_COUNT=0 sets done, pulses irq and never asserts CS_b.

States:
- IDLE → CMD on start: CS_b low, shift 32 bits MSB-first (0x03, then addr[23:16], [15:8], [7:0]).
- CMD → DATA: shift in 16 bits. The first byte received goes to word[7:0], the second to word[15:8].
- DATA → WRITE: present address and data, assert fl_wvalid. SCK is held low and CS_b stays low.
- WRITE → ACK on fl_wready=1: drop fl_wvalid, increment the memory address (wraps 0xFFFF→0x0000) and decrement the remaining count.
- ACK → DATA if count>0; otherwise → DONE.
- ACK lasts exactly one cycle and ignores fl_wready, because the arbiter's registered wready may still be high.
- DONE: CS_b high, set done, pulse irq, → IDLE.

Flash addressing: the flash byte address is consumed only at CMD. Continuous read is used and the flash auto-increments.

## Timing
- Reset values: CS_b=1, SCK=0, MOSI=0, fl_wvalid=0, fl_memory_address=0, fl_memory_data=0, DATA_OUT=0, irq=0. All registers are 0, busy=0, done=0.
- Reset mid-transfer aborts: CS_b=1 and fl_wvalid=0 on the cycle after RSTb is sampled low.
- DATA_OUT is registered: it reflects ADDRESS one cycle after it is sampled.
- Start and CS_b: CS_b falls on the cycle after the CMD write. busy reads 1 from that cycle.
- SPI bit timing: each bit takes 2×CLK_DIV cycles.
  - MOSI changes on the SCK falling edge, or at CS_b assertion for the first bit.
  - MISO is sampled on the CLK in which SCK rises.
- Per-word cost with CLK_DIV=1: 32 shift cycles, plus WRITE wait, plus 1 ACK cycle. The command phase is 64 cycles.
- fl_wvalid, address and data are stable from assertion until the cycle fl_wready is sampled high.
- After that, fl_wvalid is deasserted for ≥1 cycle, so exactly one memory write occurs per word.
- The fl_wvalid stall is unbounded: if the arbiter never grants, the block waits in WRITE indefinitely.
- A STATUS done-clear on the same cycle that DONE sets done: set wins.

## Structure
- Shared package `slurm16_flash_dma_pkg`:
  - register index constants (REG_FLASH_LO…REG_STATUS);
  - SPI_CMD_READ = 8'h03;
  - the state enum.
- Sub-module `slurm16_spi_shifter`: a CLK_DIV-paced, bidirectional shift engine with load/start/done, 8/16/32-bit length select and mode-0 SCK generation.
- The top level holds the registers, the FSM and the memory handshake.

## Test plan
- Basic transfer:
  - Stimulus: FLASH=0x012345, DMA_ADDR=0x4000, COUNT=2. The flash model returns bytes AA BB CC DD.
  - Required: MOSI bits 0x03012345; writes 0xBBAA@0x4000 and 0xDDCC@0x4001; done=1; one irq pulse; CS_b high.
- Arbiter stall:
  - Stimulus: hold fl_wready=0 for 50 cycles during WRITE.
  - Required: address/data/wvalid stable throughout; exactly one write when fl_wready rises.
- Lingering wready:
  - Stimulus: keep fl_wready high for 2 extra cycles after accept.
  - Required: no duplicate write; the next word is written correctly.
- Zero count:
  - Stimulus: COUNT=0 with start.
  - Required: CS_b never falls; done=1 and irq pulse within 2 cycles.
- Wrap and ignored write:
  - Stimulus: DMA_ADDR=0xFFFF, COUNT=2; write FLASH_LO mid-transfer.
  - Required: writes land at 0xFFFF then 0x0000; the FLASH_LO register is unchanged.
- Reset mid-transfer:
  - Stimulus: assert RSTb low during DATA.
  - Required: the next cycle shows CS_b=1, fl_wvalid=0 and all registers 0.
